// File: rtl/sparse_pkg.sv
// sparse_pkg: shared product-stream field layout, drain address width and accumulator FSM states
package sparse_pkg;
  localparam int PROD_W = 26;
  localparam int COORD_W = 5;
  localparam int VAL_W = 16;
  localparam int X_LO = 21;
  localparam int Y_LO = 16;
  localparam int V_LO = 0;
  localparam int ADDR_W = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;
endpackage

// File: rtl/psum_sat_add.sv
// psum_sat_add: adds a sign-extended product value to a partial sum.
// PSUM_SAT_EN defined: saturate to the signed ACC_W range; otherwise wrap modulo 2^ACC_W.
module psum_sat_add #(
  parameter int ACC_W = 24,
  parameter int VAL_W = 16
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [VAL_W-1:0] v,
  output logic signed [ACC_W-1:0] sum
);
  logic signed [ACC_W-1:0] b, raw;
  assign b = ACC_W'(v);
  assign raw = a + b;
`ifdef PSUM_SAT_EN
  logic ovf;
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
  assign sum = ovf ? {a[ACC_W-1], {(ACC_W-1){~a[ACC_W-1]}}} : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/psum_scatter_acc.sv
// psum_scatter_acc: scatter-accumulates {x,y,value} products into a psum map, then drains it in raster order.
// Define PSUM_SAT_EN for saturating accumulation (default build wraps).
module psum_scatter_acc
  import sparse_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int OUT_H = 8,
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_valid,
  input  logic [PROD_W-1:0]        i_data,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [ADDR_W-1:0]        o_addr,
  output logic signed [ACC_W-1:0]  o_psum,
  input  logic                     i_ready,
  output logic                     o_done,
  output logic [15:0]              o_drop_cnt
);
  localparam int XW = OUT_W > 1 ? $clog2(OUT_W) : 1;
  localparam int YW = OUT_H > 1 ? $clog2(OUT_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(OUT_H - 1);
  localparam logic [COORD_W-1:0] W_LIM = COORD_W'(OUT_W);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(OUT_H);
  state_t state, state_nx;
  logic fc, s0_v, s1_v, s1_ok, last_out, accept;
  logic [PROD_W-1:0] s0_d;
  logic [COORD_W-1:0] px, py;
  logic [XW-1:0] s1_x, dx;
  logic [YW-1:0] s1_y, dy;
  logic signed [VAL_W-1:0] s1_val;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] map [OUT_H][OUT_W];
  assign o_ready = state == ACCUM;
  assign accept = i_valid & o_ready;
  assign px = s0_d[X_LO +: COORD_W];
  assign py = s0_d[Y_LO +: COORD_W];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_start ? ACCUM : IDLE;
      ACCUM:   state_nx = (accept && i_last) ? FLUSH : ACCUM;
      FLUSH:   state_nx = fc ? DRAIN : FLUSH;
      DRAIN:   state_nx = (o_valid && i_ready && last_out) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  psum_sat_add #(.ACC_W(ACC_W), .VAL_W(VAL_W)) u_add (
    .a(map[s1_y][s1_x]),
    .v(s1_val),
    .sum(sum)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      fc <= 1'b0;
      s0_v <= 1'b0;
      s0_d <= '0;
      s1_v <= 1'b0;
      s1_ok <= 1'b0;
      s1_x <= '0;
      s1_y <= '0;
      s1_val <= '0;
      map <= '{default: '{default: '0}};
      dx <= '0;
      dy <= '0;
      last_out <= 1'b0;
      o_valid <= 1'b0;
      o_addr <= '0;
      o_psum <= '0;
      o_done <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      state <= state_nx;
      fc <= (state == FLUSH) ? ~fc : 1'b0;
      o_done <= 1'b0;
      s0_v <= accept;
      if (accept) s0_d <= i_data;
      s1_v <= s0_v;
      s1_ok <= !px[COORD_W-1] && !py[COORD_W-1] && px < W_LIM && py < H_LIM;
      s1_x <= px[XW-1:0];
      s1_y <= py[YW-1:0];
      s1_val <= s0_d[V_LO +: VAL_W];
      // S1 is the only map writer, so read-modify-write needs no forwarding
      if (state == IDLE && i_start) begin
        map <= '{default: '{default: '0}};
        o_drop_cnt <= '0;
        dx <= '0;
        dy <= '0;
        last_out <= 1'b0;
      end else if (s1_v && s1_ok) map[s1_y][s1_x] <= sum;
      else if (s1_v && o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
      if (state == DRAIN) begin
        if (o_valid && i_ready && last_out) begin
          o_valid <= 1'b0;
          o_done <= 1'b1;
        end else if (!o_valid || i_ready) begin
          o_valid <= 1'b1;
          o_addr <= {4'(dy), 4'(dx)};
          o_psum <= map[dy][dx];
          last_out <= dx == X_MAX && dy == Y_MAX;
          dx <= (dx == X_MAX) ? '0 : dx + 1'b1;
          dy <= (dx == X_MAX) ? dy + 1'b1 : dy;
        end
      end
    end
  end
endmodule

// File: tb/tb_psum_scatter_acc.sv
// tb_psum_scatter_acc: table-driven tiles through an 8x8/ACC_W=24 instance plus a 16-bit instance for overflow behaviour.
module tb_psum_scatter_acc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_start = 1'b0, i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b0;
  logic [25:0] i_data = '0;
  logic o_ready, o_valid, o_done;
  logic [7:0] o_addr;
  logic signed [23:0] o_psum;
  logic [15:0] o_drop_cnt;
  logic b_start = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic [25:0] b_data = '0;
  logic b_ready, b_ovalid, b_done;
  logic [7:0] b_addr;
  logic signed [15:0] b_psum;
  logic [15:0] b_drops;
  int n_chk = 0, n_fail = 0;
  typedef struct { int t; int x; int y; int v; bit last; } prod_t;
  typedef struct { int t; int x; int y; int psum; } exp_t;
  prod_t prods [15];
  exp_t exps [7];
  int exp_drops [4];
  int exp_map [64];

  always #5 clk = ~clk;

  psum_scatter_acc dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .o_ready(o_ready), .o_valid(o_valid), .o_addr(o_addr), .o_psum(o_psum), .i_ready(i_ready),
    .o_done(o_done), .o_drop_cnt(o_drop_cnt)
  );

  psum_scatter_acc #(.OUT_W(8), .OUT_H(8), .ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .i_start(b_start), .i_valid(b_valid), .i_data(b_data), .i_last(b_last),
    .o_ready(b_ready), .o_valid(b_ovalid), .o_addr(b_addr), .o_psum(b_psum), .i_ready(1'b1),
    .o_done(b_done), .o_drop_cnt(b_drops)
  );

  function automatic logic [25:0] mk(input int x, input int y, input int v);
    return {x[4:0], y[4:0], v[15:0]};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_tile();
    i_valid = 1'b1;
    i_data = mk(1, 1, 999);
    i_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready", o_ready, 0);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic push(input int t);
    for (int i = 0; i < 15; i++) begin
      if (prods[i].t == t) begin
        i_valid = 1'b1;
        i_data = mk(prods[i].x, prods[i].y, prods[i].v);
        i_last = prods[i].last;
        @(negedge clk);
        chk("accum_ready", o_ready, 1);
        @(posedge clk); #1;
      end
    end
    // junk held on the bus after the tile must be ignored through FLUSH and DRAIN
    i_valid = 1'b1;
    i_data = mk(2, 3, 1000);
    i_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("flush_ready", o_ready, 0);
    end
  endtask

  task automatic drain(input bit toggle, input bit start_mid);
    int n = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [7:0] ha;
    logic signed [23:0] hp;
    i_ready = 1'b1;
    while (n < 64 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("stall_addr", o_addr, ha);
        chk("stall_psum", o_psum, hp);
        stalled = 0;
      end
      if (o_valid && i_ready) begin
        chk("raster_addr", o_addr, ((n / 8) << 4) | (n % 8));
        chk("psum", o_psum, exp_map[n]);
        n++;
      end else if (o_valid) begin
        stalled = 1;
        ha = o_addr;
        hp = o_psum;
      end
      @(posedge clk); #1;
      if (toggle) i_ready = ~i_ready;
      i_start = start_mid && n == 10;
    end
    i_start = 1'b0;
    chk("drain_count", n, 64);
    @(negedge clk);
    chk("done_pulse", o_done, 1);
    chk("done_valid_low", o_valid, 0);
    chk("done_idle_ready", o_ready, 0);
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
  endtask

  task automatic build_exp(input int t);
    for (int i = 0; i < 64; i++) exp_map[i] = 0;
    for (int i = 0; i < 7; i++)
      if (exps[i].t == t) exp_map[exps[i].y * 8 + exps[i].x] = exps[i].psum;
  endtask

  task automatic run_tile(input int t, input bit toggle, input bit start_mid);
    build_exp(t);
    start_tile();
    push(t);
    drain(toggle, start_mid);
    chk("drop_cnt", o_drop_cnt, exp_drops[t]);
    i_valid = 1'b0;
    i_last = 1'b0;
  endtask

  initial begin
    int w;
    bit dn;
    prods = '{
      '{0, 2, 3, 100, 0}, '{0, 2, 3, -40, 0}, '{0, 2, 3, 5, 1},
      '{1, -1, 0, 7, 0}, '{1, 8, 0, 7, 0}, '{1, 0, 8, 7, 0}, '{1, 7, 7, 7, 1},
      '{2, 0, 0, -1, 0}, '{2, 7, 0, 32767, 0}, '{2, 7, 0, 32767, 0}, '{2, 0, 7, -32768, 0},
      '{2, 3, 5, 10, 0}, '{2, 3, 5, -10, 0}, '{2, 5, 3, 1, 1},
      '{3, -1, -1, 0, 1}
    };
    exps = '{
      '{0, 2, 3, 65}, '{1, 7, 7, 7},
      '{2, 0, 0, -1}, '{2, 7, 0, 65534}, '{2, 0, 7, -32768}, '{2, 3, 5, 0}, '{2, 5, 3, 1}
    };
    exp_drops = '{0, 3, 0, 1};
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_psum", o_psum, 0);
    chk("rst_drops", o_drop_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_tile(0, 1'b0, 1'b0);
    run_tile(1, 1'b1, 1'b0);
    run_tile(2, 1'b1, 1'b1);
    // abort mid-drain with reset, then a fresh tile must see a zero map
    start_tile();
    push(0);
    i_ready = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(o_valid && o_addr == 8'h24) && w < 300);
    chk("reach_idx20", o_addr, 8'h24);
    reset = 1'b0;
    #1;
    chk("abort_valid", o_valid, 0);
    chk("abort_ready", o_ready, 0);
    chk("abort_addr", o_addr, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      dn |= o_done;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_idle", o_ready, 0);
    run_tile(3, 1'b0, 1'b0);
    // 16-bit accumulator overflow: 3 x 16384 into (0,0)
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b_valid = 1'b1;
      b_data = mk(0, 0, 16384);
      b_last = (k == 2);
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    b_last = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!b_ovalid && w < 50);
    chk("ovf_first_addr", b_addr, 0);
`ifdef PSUM_SAT_EN
    chk("ovf_psum", b_psum, 32767);
`else
    chk("ovf_psum", b_psum, -16384);
`endif
    dn = 0;
    repeat (100) begin
      @(negedge clk);
      dn |= b_done;
    end
    chk("ovf_done", dn, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
